// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the 32-bit ALU: register file with write-back
// bypass, immediate extension, RAW scoreboard and a registered valid/ready slot.
module alu_operand_fetch #(
  parameter int N    = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [15:0]   in_imm,
  input  logic          in_use_imm,
  input  logic          in_sign_ext,
  input  logic [2:0]    in_aluctr,
  input  logic [AW-1:0] in_rd,
  input  logic          in_wr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic [2:0]    ALUctr,
  output logic [AW-1:0] out_rd,
  output logic          out_wr,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  input  logic          wb_overflow
);

  typedef struct packed {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [2:0]    ctr;
    logic [AW-1:0] rd;
    logic          wr;
  } ex_t;

  logic [N-1:0]    rf [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nx;

  logic            wq;
  logic [N-1:0]    rd_rs;
  logic [N-1:0]    rd_rt;
  logic [N-1:0]    ext_imm;
  logic            haz_rs;
  logic            haz_rt;
  logic            haz;
  logic            accept;
  logic            wb_rs;
  logic            wb_rt;

  ex_t             q;
  ex_t             q_nx;

  assign wq    = wb_en && !wb_overflow && (wb_addr != '0);
  assign wb_rs = wb_en && (wb_addr == in_rs);
  assign wb_rt = wb_en && (wb_addr == in_rt);

  // Bypass only on a write that actually lands; overflow keeps old value.
  always_comb begin
    rd_rs = rf[in_rs];
    rd_rt = rf[in_rt];
    if (wq && wb_addr == in_rs) rd_rs = wb_data;
    if (wq && wb_addr == in_rt) rd_rt = wb_data;
    if (in_rs == '0) rd_rs = '0;
    if (in_rt == '0) rd_rt = '0;
  end

  always_comb begin
    ext_imm = {16'h0000, in_imm};
    if (in_sign_ext) ext_imm = {{16{in_imm[15]}}, in_imm};
  end

  assign haz_rs   = pending[in_rs] && !wb_rs;
  assign haz_rt   = !in_use_imm && pending[in_rt] && !wb_rt;
  assign haz      = haz_rs || haz_rt;
  assign in_ready = !haz && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    q_nx     = '0;
    q_nx.a   = rd_rs;
    q_nx.b   = in_use_imm ? ext_imm : rd_rt;
    q_nx.ctr = in_aluctr;
    q_nx.rd  = in_rd;
    q_nx.wr  = in_wr;
  end

  // Set after clear so a same-cycle reissue to r stays pending.
  always_comb begin
    pending_nx = pending;
    if (wb_en) pending_nx[wb_addr] = 1'b0;
    if (accept && in_wr && in_rd != '0)
      pending_nx[in_rd] = 1'b1;
    pending_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wq) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          q         <= q_nx;
          out_valid <= 1'b1;
        end
        (!accept && out_ready): begin
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign A      = q.a;
  assign B      = q.b;
  assign ALUctr = q.ctr;
  assign out_rd = q.rd;
  assign out_wr = q.wr;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: expected operand bundles are queued
// on acceptance and compared when the ALU side handshakes.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [15:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic        in_sign_ext = 1'b0;
  logic [2:0]  in_aluctr = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUctr;
  logic [4:0]  out_rd;
  logic        out_wr;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_overflow = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mrf [32];

  alu_operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
    .in_aluctr(in_aluctr), .in_rd(in_rd), .in_wr(in_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALUctr(ALUctr),
    .out_rd(out_rd), .out_wr(out_wr),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_overflow(wb_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mrf[i] <= '0;
    end else if (wb_en && !wb_overflow && wb_addr != 0) begin
      mrf[wb_addr] <= wb_data;
    end
  end

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && !wb_overflow && wb_addr == a) return wb_data;
    return mrf[a];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #4;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty got A=%h B=%h", A, B);
      end else begin
        e = sb.pop_front();
        if ({A, B, ALUctr, out_rd, out_wr} !== e) begin
          bad++;
          $display("FAIL sb_out got=%h/%h/%h/%h/%h want=%h/%h/%h/%h/%h",
                   A, B, ALUctr, out_rd, out_wr,
                   e.a, e.b, e.c, e.rd, e.wr);
        end
      end
    end
  end

  task automatic step();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e.a = mread(in_rs);
      if (in_use_imm)
        e.b = in_sign_ext ? {{16{in_imm[15]}}, in_imm}
                          : {16'h0000, in_imm};
      else
        e.b = mread(in_rt);
      e.c  = in_aluctr;
      e.rd = in_rd;
      e.wr = in_wr;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic ui,
                           input logic se, input logic [2:0] ctr,
                           input logic [4:0] rd, input logic wr);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_imm = imm;
    in_use_imm = ui; in_sign_ext = se; in_aluctr = ctr;
    in_rd = rd; in_wr = wr;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_en = 1'b0; wb_overflow = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d; wb_overflow = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, A, B, ALUctr, out_rd, out_wr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b A=%h B=%h c=%h rd=%h wr=%b want all 0",
               out_valid, A, B, ALUctr, out_rd, out_wr);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    wb(5'd1, 32'd16); step();
    wb(5'd2, 32'd18); step();
    idle();
    set_instr(5'd1, 5'd2, 16'h0, 1'b0, 1'b0, 3'b000, 5'd9, 1'b0);
    step();
    idle();
    total++;
    if (out_valid !== 1'b1 || A !== 32'd16 || B !== 32'd18 || ALUctr !== 3'b000) begin
      bad++;
      $display("FAIL basic got v=%b A=%0d B=%0d c=%b want v=1 A=16 B=18 c=000",
               out_valid, A, B, ALUctr);
    end
    step();
  endtask

  task automatic test_imm();
    set_instr(5'd1, 5'd0, 16'hFFF8, 1'b1, 1'b1, 3'b001, 5'd0, 1'b0);
    step();
    total++;
    if (B !== 32'hFFFFFFF8 || A !== 32'd16) begin
      bad++; $display("FAIL imm_sext got A=%h B=%h want A=10 B=fffffff8", A, B);
    end
    in_sign_ext = 1'b0;
    step();
    total++;
    if (B !== 32'h0000FFF8) begin
      bad++; $display("FAIL imm_zext got B=%h want 0000fff8", B);
    end
    idle(); step();
  endtask

  task automatic test_hazard();
    set_instr(5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 3'b000, 5'd3, 1'b1);
    step();
    set_instr(5'd3, 5'd0, 16'h0001, 1'b1, 1'b0, 3'b010, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL hazard_stall got in_ready=%b want=0", in_ready);
      end
      step();
    end
    wb(5'd3, 32'd5);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL hazard_release got in_ready=%b want=1", in_ready);
    end
    step();
    idle();
    total++;
    if (out_valid !== 1'b1 || A !== 32'd5) begin
      bad++; $display("FAIL hazard_bypass got v=%b A=%0d want v=1 A=5", out_valid, A);
    end
    step();
  endtask

  task automatic test_overflow();
    set_instr(5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 3'b000, 5'd4, 1'b1);
    step();
    set_instr(5'd4, 5'd0, 16'h0002, 1'b1, 1'b0, 3'b100, 5'd0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL ovf_stall got in_ready=%b want=0", in_ready);
    end
    step();
    wb(5'd4, 32'h80000000);
    wb_overflow = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL ovf_release got in_ready=%b want=1", in_ready);
    end
    step();
    idle();
    total++;
    if (A !== 32'h0) begin
      bad++; $display("FAIL ovf_no_write got A=%h want 00000000", A);
    end
    wb(5'd0, 32'd7);
    set_instr(5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'b110, 5'd0, 1'b0);
    step();
    idle();
    total++;
    if (A !== 32'h0 || B !== 32'h0) begin
      bad++; $display("FAIL r0_zero got A=%h B=%h want 0/0", A, B);
    end
    set_instr(5'd4, 5'd4, 16'h0, 1'b0, 1'b0, 3'b111, 5'd0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL ovf_pending_clear got in_ready=%b want=1", in_ready);
    end
    step();
    idle();
    total++;
    if (A !== 32'h0 || B !== 32'h0) begin
      bad++; $display("FAIL ovf_r4 got A=%h B=%h want 0/0", A, B);
    end
    step();
  endtask

  task automatic test_backpressure();
    idle(); out_ready = 1'b1; step();
    out_ready = 1'b0;
    set_instr(5'd1, 5'd2, 16'h0, 1'b0, 1'b0, 3'b100, 5'd7, 1'b0);
    step();
    set_instr(5'd2, 5'd1, 16'h0, 1'b0, 1'b0, 3'b101, 5'd8, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || A !== 32'd16 || B !== 32'd18 ||
          ALUctr !== 3'b100 || out_rd !== 5'd7) begin
        bad++;
        $display("FAIL bp_hold got v=%b A=%0d B=%0d c=%b rd=%0d want 1/16/18/100/7",
                 out_valid, A, B, ALUctr, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_resume got in_ready=%b want=1", in_ready);
    end
    step();
    idle();
    total++;
    if (A !== 32'd18 || B !== 32'd16 || ALUctr !== 3'b101 || out_rd !== 5'd8) begin
      bad++;
      $display("FAIL bp_next got A=%0d B=%0d c=%b rd=%0d want 18/16/101/8",
               A, B, ALUctr, out_rd);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [6];
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110, 3'b111};
    for (int r = 5; r < 9; r++) begin
      wb(5'(r), $urandom); step();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_instr(5'(5 + i % 4), 5'(5 + (i + 1) % 4), 16'($urandom),
                1'(i & 1), 1'((i >> 1) & 1), ops[i], 5'(i), 1'b0);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready);
      end
      step();
    end
    idle(); step(); step();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL b2b_drain got left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 3'b000, 5'd3, 1'b1);
    step();
    idle();
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre got out_valid=%b want=1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    total++;
    if (out_valid !== 1'b0 || A !== 32'h0 || out_wr !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b A=%h wr=%b want 0/0/0", out_valid, A, out_wr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_instr(5'd3, 5'd3, 16'h0, 1'b0, 1'b0, 3'b010, 5'd0, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_pending got in_ready=%b want=1", in_ready);
    end
    step();
    idle();
    total++;
    if (out_valid !== 1'b1 || A !== 32'h0 || B !== 32'h0) begin
      bad++; $display("FAIL mid_r3 got v=%b A=%h B=%h want 1/0/0", out_valid, A, B);
    end
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_hazard();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL final_drain got left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
